// File: rtl/uart_cfg_core.sv
// Build-time configurable UART: free-running oversample tick, TX and RX engines,
// parity/framing error detection and a runtime loopback from tx to the receiver.
module uart_cfg_core #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 loopback,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_busy,
    output logic                 rx_done,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Oversample tick generator
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Transmitter
    state_t                tx_state;
    logic [OS_W-1:0]       tx_cnt;
    logic [2:0]            tx_idx;
    logic                  tx_stop_idx;
    logic [DATA_BITS-1:0]  tx_shift;
    logic [DATA_BITS-1:0]  tx_hold;
    logic                  tx_par;
    logic                  tx_accept;

    assign tx_par    = (^tx_hold) ^ ODD;
    // The tx_done cycle is already IDLE, but a start there must wait one more cycle.
    assign tx_accept = (tx_state == S_IDLE) && tx_start && !tx_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state    <= S_IDLE;
            tx_cnt      <= '0;
            tx_idx      <= '0;
            tx_stop_idx <= 1'b0;
            tx_shift    <= '0;
            tx_hold     <= '0;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
            tx_done     <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (tx_state)
                S_IDLE: begin
                    if (tx_accept) begin
                        tx_state    <= S_START;
                        tx          <= 1'b0;
                        tx_busy     <= 1'b1;
                        tx_shift    <= tx_data;
                        tx_hold     <= tx_data;
                        tx_cnt      <= '0;
                        tx_idx      <= '0;
                        tx_stop_idx <= 1'b0;
                    end
                end
                default: begin
                    if (tick) begin
                        if (tx_cnt != OS_LAST) begin
                            tx_cnt <= tx_cnt + 1'b1;
                        end else begin
                            tx_cnt <= '0;
                            case (tx_state)
                                S_START: begin
                                    tx_state <= S_DATA;
                                    tx       <= tx_shift[0];
                                end
                                S_DATA: begin
                                    if (tx_idx != DATA_LAST) begin
                                        tx_idx   <= tx_idx + 1'b1;
                                        tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
                                        tx       <= tx_shift[1];
                                    end else if (PARITY_EN != 0) begin
                                        tx_state <= S_PARITY;
                                        tx       <= tx_par;
                                    end else begin
                                        tx_state <= S_STOP;
                                        tx       <= 1'b1;
                                    end
                                end
                                S_PARITY: begin
                                    tx_state <= S_STOP;
                                    tx       <= 1'b1;
                                end
                                S_STOP: begin
                                    if (tx_stop_idx == STOP_LAST) begin
                                        tx_state <= S_IDLE;
                                        tx_busy  <= 1'b0;
                                        tx_done  <= 1'b1;
                                    end else begin
                                        tx_stop_idx <= 1'b1;
                                    end
                                end
                                default: tx_state <= S_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    // Receiver input: two-flop synchroniser, then the loopback mux
    logic rx_meta;
    logic rx_sync;
    logic rx_line;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    assign rx_line = loopback ? tx : rx_sync;

    // Receiver: samples only on ticks, mid-bit after a validated start
    state_t                rx_state;
    logic [OS_W-1:0]       rx_cnt;
    logic [2:0]            rx_idx;
    logic                  rx_stop_idx;
    logic [DATA_BITS-1:0]  rx_shift;
    logic                  rx_par_bit;
    logic                  rx_bad_stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= S_IDLE;
            rx_cnt      <= '0;
            rx_idx      <= '0;
            rx_stop_idx <= 1'b0;
            rx_shift    <= '0;
            rx_par_bit  <= 1'b0;
            rx_bad_stop <= 1'b0;
            rx_data     <= '0;
            rx_busy     <= 1'b0;
            rx_done     <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (tick) begin
                case (rx_state)
                    S_IDLE: begin
                        if (!rx_line) begin
                            rx_state <= S_START;
                            rx_cnt   <= '0;
                        end
                    end
                    S_START: begin
                        if (rx_cnt != OS_HALF) begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end else begin
                            rx_cnt <= '0;
                            // A start that is high again at mid-bit was a glitch.
                            if (!rx_line) begin
                                rx_state    <= S_DATA;
                                rx_busy     <= 1'b1;
                                rx_idx      <= '0;
                                rx_stop_idx <= 1'b0;
                                rx_par_bit  <= 1'b0;
                                rx_bad_stop <= 1'b0;
                            end else begin
                                rx_state <= S_IDLE;
                            end
                        end
                    end
                    default: begin
                        if (rx_cnt != OS_LAST) begin
                            rx_cnt <= rx_cnt + 1'b1;
                        end else begin
                            rx_cnt <= '0;
                            case (rx_state)
                                S_DATA: begin
                                    rx_shift <= {rx_line, rx_shift[DATA_BITS-1:1]};
                                    if (rx_idx != DATA_LAST) begin
                                        rx_idx <= rx_idx + 1'b1;
                                    end else begin
                                        rx_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                                    end
                                end
                                S_PARITY: begin
                                    rx_par_bit <= rx_line;
                                    rx_state   <= S_STOP;
                                end
                                S_STOP: begin
                                    if (rx_stop_idx != STOP_LAST) begin
                                        rx_stop_idx <= 1'b1;
                                        rx_bad_stop <= rx_bad_stop | ~rx_line;
                                    end else begin
                                        rx_state   <= S_IDLE;
                                        rx_busy    <= 1'b0;
                                        rx_done    <= 1'b1;
                                        rx_data    <= rx_shift;
                                        frame_err  <= rx_bad_stop | ~rx_line;
                                        parity_err <= (PARITY_EN != 0) ?
                                                      (rx_par_bit ^ (^rx_shift) ^ ODD) : 1'b0;
                                    end
                                end
                                default: rx_state <= S_IDLE;
                            endcase
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_cfg_core.sv
// Bench for uart_cfg_core: three build-time configurations checked against a
// frame-level model, a constant vector table and directed multi-cycle sequences.
module tb_uart_cfg_core;

    localparam int CF  = 1_000_000;
    localparam int BR  = 31250;   // OVERSAMPLE 16 -> DIV 2
    localparam int BR2 = 62500;   // OVERSAMPLE 8  -> DIV 2
    localparam int DIV = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] loopback_v = '0;
    logic [2:0] tx_start_v = '0;
    logic [2:0] rx_pin_v   = '1;
    logic [7:0] tx_data_v [3] = '{8'h00, 8'h00, 8'h00};

    wire [2:0] tx_w, tx_busy_w, tx_done_w, rx_busy_w, rx_done_w, perr_w, ferr_w;
    wire [7:0] rx_data0, rx_data2;
    wire [6:0] rx_data1;

    // 8N1
    uart_cfg_core #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(16), .DATA_BITS(8),
                    .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .loopback(loopback_v[0]), .tx_data(tx_data_v[0]),
        .tx_start(tx_start_v[0]), .tx(tx_w[0]), .tx_busy(tx_busy_w[0]), .tx_done(tx_done_w[0]),
        .rx(rx_pin_v[0]), .rx_data(rx_data0), .rx_busy(rx_busy_w[0]), .rx_done(rx_done_w[0]),
        .parity_err(perr_w[0]), .frame_err(ferr_w[0]));

    // 7 data, odd parity, 2 stop
    uart_cfg_core #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(16), .DATA_BITS(7),
                    .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u1 (
        .clk(clk), .rst(rst), .loopback(loopback_v[1]), .tx_data(tx_data_v[1][6:0]),
        .tx_start(tx_start_v[1]), .tx(tx_w[1]), .tx_busy(tx_busy_w[1]), .tx_done(tx_done_w[1]),
        .rx(rx_pin_v[1]), .rx_data(rx_data1), .rx_busy(rx_busy_w[1]), .rx_done(rx_done_w[1]),
        .parity_err(perr_w[1]), .frame_err(ferr_w[1]));

    // 8 data, even parity, 1 stop, OVERSAMPLE 8
    uart_cfg_core #(.CLK_FREQ(CF), .BAUD_RATE(BR2), .OVERSAMPLE(8), .DATA_BITS(8),
                    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .loopback(loopback_v[2]), .tx_data(tx_data_v[2]),
        .tx_start(tx_start_v[2]), .tx(tx_w[2]), .tx_busy(tx_busy_w[2]), .tx_done(tx_done_w[2]),
        .rx(rx_pin_v[2]), .rx_data(rx_data2), .rx_busy(rx_busy_w[2]), .rx_done(rx_done_w[2]),
        .parity_err(perr_w[2]), .frame_err(ferr_w[2]));

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];   // {inst, frame_err, parity_err, rx_data}
    int txd_cnt [3] = '{0, 0, 0};
    int rxd_cnt [3] = '{0, 0, 0};

    function automatic int dbits(int i);  return (i == 1) ? 7 : 8;   endfunction
    function automatic bit pen(int i);    return (i != 0);           endfunction
    function automatic bit odd(int i);    return (i == 1);           endfunction
    function automatic int nstop(int i);  return (i == 1) ? 2 : 1;   endfunction
    function automatic int bitc(int i);   return (i == 2) ? 16 : 32; endfunction
    function automatic int flen(int i);   return 1 + dbits(i) + int'(pen(i)) + nstop(i); endfunction
    function automatic logic [7:0] dmask(int i); return (i == 1) ? 8'h7F : 8'hFF; endfunction

    function automatic logic [7:0] rx_data_of(int i);
        case (i)
            0:       return rx_data0;
            1:       return {1'b0, rx_data1};
            default: return rx_data2;
        endcase
    endfunction

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Line levels of a frame, bit k at index k, built from the framing rules.
    function automatic logic [11:0] frame_vec(int i, logic [7:0] d, bit pflip, logic [1:0] bad_stop);
        logic [11:0] v;
        int ones;
        int pos;
        v    = '1;
        v[0] = 1'b0;
        ones = 0;
        for (int k = 0; k < dbits(i); k++) begin
            v[1+k] = d[k];
            ones += int'(d[k]);
        end
        pos = 1 + dbits(i);
        if (pen(i)) begin
            v[pos] = (((ones % 2) == 1) != odd(i)) ^ pflip;
            pos++;
        end
        for (int s = 0; s < nstop(i); s++) v[pos+s] = ~bad_stop[s];
        return v;
    endfunction

    function automatic logic [11:0] model_exp(int i, logic [7:0] d, bit pflip, logic [1:0] bad_stop);
        logic [1:0] smask;
        smask = (nstop(i) == 2) ? 2'b11 : 2'b01;
        return {2'(i), |(bad_stop & smask), pen(i) & pflip, d & dmask(i)};
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (tx_done_w[i] === 1'b1) txd_cnt[i]++;
            if (rx_done_w[i] === 1'b1) begin
                rxd_cnt[i]++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected inst %0d: got %0h expected no frame", i,
                             {2'(i), ferr_w[i], perr_w[i], rx_data_of(i)});
                end else begin
                    check($sformatf("rx_frame%0d", i),
                          {2'(i), ferr_w[i], perr_w[i], rx_data_of(i)}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Transmit one frame; checks every line level mid-bit and the tx_done timing.
    task automatic send_tx(input int i, input logic [7:0] d, input int poke_k, input logic [11:0] exp);
        logic [11:0] fv;
        int n, b, a, t0;
        fv = frame_vec(i, d, 1'b0, 2'b00);
        n  = flen(i);
        b  = bitc(i);
        t0 = cyc;
        while (tx_busy_w[i] && cyc < t0 + 20 * b) @(negedge clk);
        check("tx_idle_wait", tx_busy_w[i], 0);
        tx_data_v[i]  = d;
        tx_start_v[i] = 1'b1;
        @(negedge clk);
        tx_start_v[i] = 1'b0;
        a = cyc;
        check($sformatf("tx_busy_rise%0d", i), tx_busy_w[i], 1);
        if (loopback_v[i]) exp_q.push_back(exp);
        for (int k = 0; k < n; k++) begin
            wait_cyc(a + k * b + b / 2);
            check($sformatf("tx_bit%0d_%0d", i, k), tx_w[i], fv[k]);
            if (loopback_v[i] && k == 2) check($sformatf("rx_busy_lb%0d", i), rx_busy_w[i], 1);
            if (k == poke_k) begin
                tx_data_v[i]  = ~d;
                tx_start_v[i] = 1'b1;
                @(negedge clk);
                tx_start_v[i] = 1'b0;
            end
        end
        while (!tx_done_w[i] && cyc < a + n * b + 4) @(negedge clk);
        check($sformatf("tx_done_seen%0d", i), tx_done_w[i], 1);
        check($sformatf("tx_done_time%0d", i),
              ((cyc - a) >= n * b - DIV) && ((cyc - a) <= n * b), 1);
        check($sformatf("tx_busy_fall%0d", i), tx_busy_w[i], 0);
        if (loopback_v[i]) check("rx_lb_drained", exp_q.size(), 0);
    endtask

    // Drive one frame onto an rx pin with optional parity/stop corruption.
    task automatic drive_rx(input int i, input logic [7:0] d, input bit pflip,
                            input logic [1:0] bad_stop, input logic [11:0] exp);
        logic [11:0] fv;
        int n, b;
        fv = frame_vec(i, d, pflip, bad_stop);
        n  = flen(i);
        b  = bitc(i);
        exp_q.push_back(exp);
        for (int k = 0; k < n; k++) begin
            rx_pin_v[i] = fv[k];
            repeat (b / 2) @(negedge clk);
            if (k == 2) check($sformatf("rx_busy_pin%0d", i), rx_busy_w[i], 1);
            repeat (b - b / 2) @(negedge clk);
        end
        rx_pin_v[i] = 1'b1;
        repeat (4) @(negedge clk);
        check("rx_pin_drained", exp_q.size(), 0);
    endtask

    typedef struct {
        int         inst;
        bit         lb;
        logic [7:0] data;
        bit         pflip;
        logic [1:0] bad_stop;
        logic [7:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] e;
        int b, c0, a, n;
        logic any_busy;

        tbl[0]  = '{0, 1'b1, 8'hA5, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0};
        tbl[1]  = '{1, 1'b1, 8'h41, 1'b0, 2'b00, 8'h41, 1'b0, 1'b0};
        tbl[2]  = '{2, 1'b0, 8'h03, 1'b1, 2'b00, 8'h03, 1'b1, 1'b0};
        tbl[3]  = '{2, 1'b0, 8'h3C, 1'b0, 2'b00, 8'h3C, 1'b0, 1'b0};
        tbl[4]  = '{0, 1'b0, 8'h55, 1'b0, 2'b01, 8'h55, 1'b0, 1'b1};
        tbl[5]  = '{0, 1'b0, 8'h55, 1'b0, 2'b00, 8'h55, 1'b0, 1'b0};
        tbl[6]  = '{1, 1'b0, 8'h2A, 1'b0, 2'b10, 8'h2A, 1'b0, 1'b1};
        tbl[7]  = '{1, 1'b0, 8'h7F, 1'b1, 2'b00, 8'h7F, 1'b1, 1'b0};
        tbl[8]  = '{2, 1'b1, 8'hFF, 1'b0, 2'b00, 8'hFF, 1'b0, 1'b0};
        tbl[9]  = '{1, 1'b0, 8'h00, 1'b0, 2'b01, 8'h00, 1'b0, 1'b1};
        tbl[10] = '{2, 1'b0, 8'h80, 1'b1, 2'b01, 8'h80, 1'b1, 1'b1};
        tbl[11] = '{0, 1'b1, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0};
        tbl[12] = '{0, 1'b0, 8'hC3, 1'b1, 2'b00, 8'hC3, 1'b0, 1'b0};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_state%0d", i),
                  {tx_w[i], tx_busy_w[i], tx_done_w[i], rx_busy_w[i], rx_done_w[i],
                   perr_w[i], ferr_w[i], rx_data_of(i)}, {1'b1, 14'h0});
        end

        for (int j = 0; j < 13; j++) begin
            loopback_v[tbl[j].inst] = tbl[j].lb;
            e = {2'(tbl[j].inst), tbl[j].exp_ferr, tbl[j].exp_perr, tbl[j].exp_data};
            if (tbl[j].lb) send_tx(tbl[j].inst, tbl[j].data, -1, e);
            else drive_rx(tbl[j].inst, tbl[j].data, tbl[j].pflip, tbl[j].bad_stop, e);
            repeat (3) @(negedge clk);
        end

        // Start glitches of 4 and 6 ticks must not open a frame.
        loopback_v[0] = 1'b0;
        foreach (tbl[j]) begin end
        for (int g = 4; g <= 6; g += 2) begin
            c0 = rxd_cnt[0];
            any_busy = 1'b0;
            rx_pin_v[0] = 1'b0;
            repeat (g * DIV) @(negedge clk);
            rx_pin_v[0] = 1'b1;
            repeat (2 * bitc(0)) begin
                @(negedge clk);
                any_busy |= rx_busy_w[0];
            end
            check($sformatf("glitch_busy%0d", g), any_busy, 0);
            check($sformatf("glitch_done%0d", g), rxd_cnt[0] - c0, 0);
        end

        // tx_start while busy is ignored.
        loopback_v[0] = 1'b1;
        c0 = txd_cnt[0];
        send_tx(0, 8'h5A, 4, {2'd0, 2'b00, 8'h5A});
        repeat (2 * bitc(0)) @(negedge clk);
        check("busy_start_ignored", txd_cnt[0] - c0, 1);
        check("busy_start_idle", tx_busy_w[0], 0);

        // Back-to-back: start held on the tx_done cycle is taken one cycle later.
        loopback_v[2] = 1'b1;
        send_tx(2, 8'h12, -1, {2'd2, 2'b00, 8'h12});
        tx_data_v[2]  = 8'h34;
        tx_start_v[2] = 1'b1;
        exp_q.push_back({2'd2, 2'b00, 8'h34});
        @(negedge clk);
        check("b2b_reject", {tx_busy_w[2], tx_w[2]}, 2'b01);
        @(negedge clk);
        tx_start_v[2] = 1'b0;
        a = cyc;
        check("b2b_accept", {tx_busy_w[2], tx_w[2]}, 2'b10);
        n = flen(2);
        while (!tx_done_w[2] && cyc < a + n * bitc(2) + 4) @(negedge clk);
        check("b2b_done", tx_done_w[2], 1);
        repeat (2) @(negedge clk);
        check("b2b_drained", exp_q.size(), 0);

        // Reset mid-frame aborts both engines at once.
        loopback_v[1] = 1'b1;
        tx_data_v[1]  = 8'h66;
        tx_start_v[1] = 1'b1;
        @(negedge clk);
        tx_start_v[1] = 1'b0;
        repeat (4 * bitc(1)) @(negedge clk);
        check("rst_pre_busy", {tx_busy_w[1], rx_busy_w[1]}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_abort", {tx_w[1], tx_busy_w[1], rx_busy_w[1], rx_done_w[1], tx_done_w[1]}, 5'b10000);
        repeat (bitc(1)) @(negedge clk);
        send_tx(1, 8'h3C, -1, {2'd1, 2'b00, 8'h3C});

        // Randomised frames against the frame model.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 3; i++) begin
                logic [7:0] d;
                bit pf;
                logic [1:0] bs;
                b  = bitc(i);
                d  = 8'($urandom_range(0, 255));
                loopback_v[i] = 1'($urandom_range(0, 1));
                if (loopback_v[i]) begin
                    send_tx(i, d, -1, model_exp(i, d, 1'b0, 2'b00));
                end else begin
                    pf = ($urandom_range(0, 3) == 0);
                    bs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                    drive_rx(i, d, pf, bs, model_exp(i, d, pf, bs));
                end
                repeat ($urandom_range(1, b)) @(negedge clk);
            end
        end

        repeat (8) @(negedge clk);
        check("final_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
